// File: rtl/mux_arbiter_rr4.sv
// rtl/mux_arbiter_rr4.sv - four-way round-robin burst arbiter driving a registered 4:1 data mux
module mux_arbiter_rr4 #(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   ptr;
    logic [1:0]   ptr_nxt;
    logic [1:0]   sel;
    logic [1:0]   sel_nxt;
    logic [3:0]   cnt;
    logic [3:0]   cnt_nxt;
    logic [1:0]   pick;
    logic [W-1:0] sel_data;
    logic         slot_free;
    logic         accept;

    // Output slot can take a new beat when empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;
    // Held in reset, nothing is accepted so no requester sees a phantom ack.
    assign accept    = rst_n && (state == GRANT) && req[sel] && slot_free;
    assign busy      = rst_n && (state == GRANT);
    assign out_sel   = sel;

    // Round-robin search: first requester at or after ptr, wrapping mod 4.
    always_comb begin
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick = ptr + 2'(k);
            end
        end
    end

    // Shared 4:1 data mux steered by the current grant holder.
    always_comb begin
        sel_data = d0;
        case (sel)
            2'd0: sel_data = d0;
            2'd1: sel_data = d1;
            2'd2: sel_data = d2;
            2'd3: sel_data = d3;
            default: sel_data = d0;
        endcase
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        ack       = 4'b0000;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_nxt   = pick;
                    cnt_nxt   = 4'd0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + 2'd1;
                end else if (accept) begin
                    ack     = 4'b0001 << sel;
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        ptr_nxt   = sel + 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output register: load on accept, otherwise drain when consumed, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_arbiter_rr4.md
MUX_ARBITER_RR4 -- requirements
Module: mux_arbiter_rr4

Interface
REQ-001 Parameter: W, default 4, width of each data input and out_data.
REQ-002 Parameter: MAX_BURST, default 4, maximum beats per grant tenure; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  4  req[i]=1: requester i holds a valid beat on d<i>.
REQ-006 d0, d1, d2, d3  input  W each  requester data.
REQ-007 ack  output  4  one-hot or zero; ack[i]=1: beat from d<i> accepted this cycle.
REQ-008 out_valid  output  1  out_data holds an unconsumed beat.
REQ-009 out_ready  input  1  downstream consumes the beat when out_valid and out_ready are both 1.
REQ-010 out_data  output  W  registered selected beat.
REQ-011 out_sel  output  2  index of current or last grant holder; drives the shared 4:1 mux select.
REQ-012 busy  output  1  1 while in state GRANT.

Function
REQ-013 FSM states SHALL be IDLE and GRANT; internal registers SHALL be ptr[1:0] (round-robin start), sel[1:0], cnt[3:0] (beats in tenure) and the output register.
REQ-014 In IDLE with req!=0, the block SHALL pick the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4; it SHALL load sel=i and cnt=0, and enter GRANT next cycle.
REQ-015 In IDLE with req==0, the state SHALL remain IDLE; ack SHALL be 0.
REQ-016 In IDLE, ack SHALL be 0: an arbitration decision costs exactly one cycle.
REQ-017 A slot is free when out_valid==0 or out_ready==1.
REQ-018 In GRANT, a beat is accepted when req[sel]=1 and the slot is free.
REQ-019 On an accepted beat, ack[sel] SHALL be 1 combinationally in that cycle, with all other ack bits 0.
REQ-020 On an accepted beat, out_data SHALL load the sel-th input (d0..d3) and out_valid SHALL be 1 next cycle.
REQ-021 On an accepted beat, cnt SHALL increment.
REQ-022 Data latency SHALL be 1 cycle from ack to out_data/out_valid.
REQ-023 The output register SHALL support simultaneous consume and load (full throughput, one beat per cycle).
REQ-024 If out_valid and out_ready are 1 and no beat is accepted, out_valid SHALL be 0 next cycle.
REQ-025 If out_valid=1 and out_ready=0, out_data and out_valid SHALL hold.
REQ-026 In GRANT with req[sel]=1 and the slot not free, the block SHALL stall: state, cnt and sel hold, ack=0.
REQ-027 Release: the block SHALL return to IDLE next cycle when req[sel]=0 in GRANT.
REQ-028 Release: the block SHALL return to IDLE next cycle when a beat is accepted with cnt==MAX_BURST-1.
REQ-029 On release, ptr SHALL become sel+1 mod 4, which wraps from 3 to 0.
REQ-030 Requests from other indices SHALL never preempt a tenure.
REQ-031 out_sel SHALL equal sel at all times, and SHALL hold its value in IDLE.
REQ-032 A requester SHALL keep req[i] and d<i> stable until ack[i]; the block does not check this rule.
REQ-033 ack[i] SHALL never be 1 when req[i]=0.
REQ-034 Fairness: a continuously requesting requester SHALL be granted within 3 tenures of other requesters.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force state=IDLE, ptr=0, sel=0, cnt=0, out_valid=0 and out_data=0, regardless of state.
REQ-036 While rst_n=0, ack SHALL be 0 and busy SHALL be 0.
REQ-037 Reset mid-tenure SHALL drop any pending output beat.
REQ-038 The first grant after reset SHALL search starting at index 0.

Verification
REQ-039 Reset, then req=4'b1111 with out_ready=1 and MAX_BURST=4 -> grants in order 0,1,2,3,0; each tenure gives 4 consecutive ack pulses then 1 IDLE cycle; out_sel follows.
REQ-040 Only req[2]=1, d2=4'hA, out_ready=1 -> IDLE 1 cycle, then ack[2] every cycle, out_data=4'hA one cycle after each ack, release after 4 beats, regrant to 2 after 1 IDLE cycle.
REQ-041 Grant to 1, out_ready=0 after the first beat -> ack=0, out_data and out_valid hold, cnt frozen; out_ready=1 -> transfer resumes with no lost or duplicated beat.
REQ-042 Grant to 3, req[3] drops after 2 beats while req[0]=1 -> IDLE next cycle, then grant to 0 (wrap-around).
REQ-043 rst_n=0 for 1 cycle during the second beat of a tenure -> next cycle out_valid=0, busy=0, ack=0; with req=4'b1010 the next grant goes to 1.
REQ-044 Scoreboard under random req, out_ready and data for 10k cycles -> every acked beat appears on out_data exactly once, in order; ack is never set without req; per-requester wait never exceeds 3 tenures.
